// File: rtl/branch_target_predictor.sv
// Branch target buffer with per-entry saturating direction counters for slot-1 fetch prediction.
// Define BTP_GSHARE_EN to XOR a non-speculative global history register into the table index.
module branch_target_predictor #(
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  parameter int TAG_W   = 8,
  parameter int GHR_W   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lookup_en_f,
  input  logic [31:0]      pc_f,
  output logic             predict_taken_f,
  output logic [31:0]      target_f,
  output logic [CTR_W-1:0] hist_f,
  output logic [GHR_W-1:0] ghr_f,
  input  logic             upd_valid_e,
  input  logic [31:0]      upd_pc_e,
  input  logic [31:0]      upd_target_e,
  input  logic             upd_taken_e,
  input  logic [CTR_W-1:0] upd_hist_e,
  input  logic [GHR_W-1:0] upd_ghr_e,
  input  logic             upd_mispredict_e,
  output logic [15:0]      mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CtrWnt = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CtrWt  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CtrMax = '1;

  logic             entryValid_q  [ENTRIES];
  logic [TAG_W-1:0] entryTag_q    [ENTRIES];
  logic [CTR_W-1:0] entryCtr_q    [ENTRIES];
  logic [31:0]      entryTarget_q [ENTRIES];
  logic [15:0]      missCount_q;

  logic [IDX_W-1:0] lookupIdx;
  logic [TAG_W-1:0] lookupTag;
  logic             lookupHit;
  logic [IDX_W-1:0] updIdx;
  logic [TAG_W-1:0] updTag;
  logic             updHit;
  logic [CTR_W:0]   ctrStep;
  logic [CTR_W-1:0] ctrClamped;
  logic             entryWe;
  logic [TAG_W-1:0] entryTag_d;
  logic [CTR_W-1:0] entryCtr_d;
  logic [31:0]      entryTarget_d;
  logic             unusedBits;

`ifdef BTP_GSHARE_EN
  logic [GHR_W-1:0] ghr_q;

  // History shifts in the resolved direction of every update, never speculative fetch outcomes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr_q <= '0;
    end else if (upd_valid_e) begin
      ghr_q <= {ghr_q[GHR_W-2:0], upd_taken_e};
    end
  end

  assign lookupIdx  = pc_f[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign updIdx     = upd_pc_e[IDX_W+1:2] ^ IDX_W'(upd_ghr_e);
  assign ghr_f      = ghr_q;
  assign unusedBits = ^{pc_f, upd_pc_e};
`else
  assign lookupIdx  = pc_f[IDX_W+1:2];
  assign updIdx     = upd_pc_e[IDX_W+1:2];
  assign ghr_f      = '0;
  assign unusedBits = ^{pc_f, upd_pc_e, upd_ghr_e};
`endif

  assign lookupTag = pc_f[IDX_W+TAG_W+1:IDX_W+2];
  assign updTag    = upd_pc_e[IDX_W+TAG_W+1:IDX_W+2];

  // Fetch-side read sees only registered contents, so a same-cycle update is not bypassed.
  always_comb begin
    lookupHit       = lookup_en_f && entryValid_q[lookupIdx] && (entryTag_q[lookupIdx] == lookupTag);
    predict_taken_f = 1'b0;
    target_f        = '0;
    hist_f          = CtrWnt;
    if (lookupHit) begin
      predict_taken_f = entryCtr_q[lookupIdx][CTR_W-1];
      target_f        = entryTarget_q[lookupIdx];
      hist_f          = entryCtr_q[lookupIdx];
    end
  end

  // Counter step uses one extra bit so overflow and underflow both show up in the MSB.
  always_comb begin
    ctrStep    = upd_taken_e ? ({1'b0, upd_hist_e} + 1'b1) : ({1'b0, upd_hist_e} - 1'b1);
    ctrClamped = ctrStep[CTR_W-1:0];
    if (ctrStep[CTR_W]) begin
      ctrClamped = upd_taken_e ? CtrMax : '0;
    end
  end

  always_comb begin
    updHit        = entryValid_q[updIdx] && (entryTag_q[updIdx] == updTag);
    entryWe       = upd_valid_e && (updHit || upd_taken_e);
    entryTag_d    = updTag;
    entryCtr_d    = updHit ? ctrClamped : CtrWt;
    entryTarget_d = upd_taken_e ? upd_target_e : entryTarget_q[updIdx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entryValid_q[i]  <= 1'b0;
        entryTag_q[i]    <= '0;
        entryCtr_q[i]    <= CtrWnt;
        entryTarget_q[i] <= '0;
      end
    end else if (entryWe) begin
      entryValid_q[updIdx]  <= 1'b1;
      entryTag_q[updIdx]    <= entryTag_d;
      entryCtr_q[updIdx]    <= entryCtr_d;
      entryTarget_q[updIdx] <= entryTarget_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      missCount_q <= '0;
    end else if (upd_valid_e && upd_mispredict_e && (missCount_q != 16'hFFFF)) begin
      missCount_q <= missCount_q + 16'd1;
    end
  end

  assign mispredict_count = missCount_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor: directed vector table, corner sequences,
// and randomized traffic against an array-based reference model.
module tb_branch_target_predictor;

  localparam int ENTRIES = 64;
  localparam int CTR_W   = 2;
  localparam int TAG_W   = 8;
  localparam int GHR_W   = 6;
  localparam int IDX_W   = 6;

  logic             clk;
  logic             reset;
  logic             lookup_en_f;
  logic [31:0]      pc_f;
  logic             predict_taken_f;
  logic [31:0]      target_f;
  logic [CTR_W-1:0] hist_f;
  logic [GHR_W-1:0] ghr_f;
  logic             upd_valid_e;
  logic [31:0]      upd_pc_e;
  logic [31:0]      upd_target_e;
  logic             upd_taken_e;
  logic [CTR_W-1:0] upd_hist_e;
  logic [GHR_W-1:0] upd_ghr_e;
  logic             upd_mispredict_e;
  logic [15:0]      mispredict_count;

  int checks;
  int failures;

  typedef struct {
    logic        updValid;
    logic [31:0] updPc;
    logic [31:0] updTarget;
    logic        updTaken;
    logic [1:0]  updHist;
    logic        lookupEn;
    logic [31:0] lookupPc;
    logic        expTaken;
    logic [31:0] expTarget;
    logic [1:0]  expHist;
  } vec_t;

  vec_t vecs [14];

  // Reference model state
  int          mValid [ENTRIES];
  int          mTag   [ENTRIES];
  int          mCtr   [ENTRIES];
  logic [31:0] mTgt   [ENTRIES];
  int          mCnt;

  branch_target_predictor #(
    .ENTRIES(ENTRIES), .CTR_W(CTR_W), .TAG_W(TAG_W), .GHR_W(GHR_W)
  ) dut (
    .clk(clk), .reset(reset),
    .lookup_en_f(lookup_en_f), .pc_f(pc_f),
    .predict_taken_f(predict_taken_f), .target_f(target_f),
    .hist_f(hist_f), .ghr_f(ghr_f),
    .upd_valid_e(upd_valid_e), .upd_pc_e(upd_pc_e), .upd_target_e(upd_target_e),
    .upd_taken_e(upd_taken_e), .upd_hist_e(upd_hist_e), .upd_ghr_e(upd_ghr_e),
    .upd_mispredict_e(upd_mispredict_e), .mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                               input logic ut, input logic [1:0] uh, input logic um,
                               input logic le, input logic [31:0] lpc);
    upd_valid_e      = uv;
    upd_pc_e         = upc;
    upd_target_e     = utgt;
    upd_taken_e      = ut;
    upd_hist_e       = uh;
    upd_mispredict_e = um;
    lookup_en_f      = le;
    pc_f             = lpc;
  endtask

  task automatic checkLookup(input string name, input logic expTaken, input logic [31:0] expTarget,
                             input logic [1:0] expHist);
    checkOutput({name, ".taken"},  32'(predict_taken_f), 32'(expTaken));
    checkOutput({name, ".target"}, target_f, expTarget);
    checkOutput({name, ".hist"},   32'(hist_f), 32'(expHist));
  endtask

  function automatic int idxOf(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int tagOf(input logic [31:0] pc);
    return int'((pc / (4 * ENTRIES)) % (1 << TAG_W));
  endfunction

  task automatic modelClear();
    for (int i = 0; i < ENTRIES; i++) begin
      mValid[i] = 0;
      mTag[i]   = 0;
      mCtr[i]   = 1;
      mTgt[i]   = 32'h0;
    end
    mCnt = 0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    upd_ghr_e = '0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;

    // Reset held for two cycles, then a lookup must miss
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.count", 32'(mispredict_count), 32'h0);
    checkOutput("rst.ghr", 32'(ghr_f), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0040_0010);
    #1;
    checkLookup("rst.lookup", 1'b0, 32'h0, 2'b01);

    vecs[0]  = '{1'b1, 32'h0040_0010, 32'h0040_0100, 1'b1, 2'b01, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 2'b10};
    vecs[1]  = '{1'b1, 32'h0040_0010, 32'h0040_0100, 1'b1, 2'b10, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 2'b11};
    vecs[2]  = '{1'b1, 32'h0040_0010, 32'h0040_0100, 1'b1, 2'b11, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 2'b11};
    vecs[3]  = '{1'b1, 32'h0040_0010, 32'h0040_0100, 1'b1, 2'b11, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 2'b11};
    vecs[4]  = '{1'b1, 32'h0040_0010, 32'h0040_0100, 1'b1, 2'b11, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 2'b11};
    vecs[5]  = '{1'b1, 32'h0040_0010, 32'h0000_0000, 1'b0, 2'b11, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 2'b10};
    vecs[6]  = '{1'b1, 32'h0040_0010, 32'h0000_0000, 1'b0, 2'b10, 1'b1, 32'h0040_0010, 1'b0, 32'h0040_0100, 2'b01};
    vecs[7]  = '{1'b1, 32'h0040_0010, 32'h0000_0000, 1'b0, 2'b01, 1'b1, 32'h0040_0010, 1'b0, 32'h0040_0100, 2'b00};
    vecs[8]  = '{1'b1, 32'h0040_0010, 32'h0000_0000, 1'b0, 2'b00, 1'b1, 32'h0040_0010, 1'b0, 32'h0040_0100, 2'b00};
    vecs[9]  = '{1'b1, 32'h0040_0110, 32'h0040_0200, 1'b1, 2'b01, 1'b1, 32'h0040_0010, 1'b0, 32'h0000_0000, 2'b01};
    vecs[10] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 2'b00, 1'b1, 32'h0040_0110, 1'b1, 32'h0040_0200, 2'b10};
    vecs[11] = '{1'b1, 32'h0040_0010, 32'h0040_0300, 1'b0, 2'b01, 1'b1, 32'h0040_0010, 1'b0, 32'h0000_0000, 2'b01};
    vecs[12] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 2'b00, 1'b1, 32'h0040_0110, 1'b1, 32'h0040_0200, 2'b10};
    vecs[13] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 2'b00, 1'b0, 32'h0040_0110, 1'b0, 32'h0000_0000, 2'b01};

    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      applyStimulus(vecs[v].updValid, vecs[v].updPc, vecs[v].updTarget, vecs[v].updTaken,
                    vecs[v].updHist, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, vecs[v].lookupEn, vecs[v].lookupPc);
      #1;
      checkLookup($sformatf("vec%0d", v), vecs[v].expTaken, vecs[v].expTarget, vecs[v].expHist);
    end

    // Same-cycle lookup and update on one index: old counter now, new counter next cycle
    @(negedge clk);
    applyStimulus(1'b1, 32'h0040_0110, 32'h0040_0200, 1'b1, 2'b10, 1'b0, 1'b1, 32'h0040_0110);
    #1;
    checkLookup("same.before", 1'b1, 32'h0040_0200, 2'b10);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0040_0110);
    #1;
    checkLookup("same.after", 1'b1, 32'h0040_0200, 2'b11);

    // Five qualified mispredicts plus three unqualified strobes
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      applyStimulus(i < 5, 32'h0040_0800, 32'h0, 1'b0, 2'b01, 1'b1, 1'b1, 32'h0040_0110);
    end
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0040_0110);
    #1;
    checkOutput("miss.five", 32'(mispredict_count), 32'd5);
    checkLookup("miss.table", 1'b1, 32'h0040_0200, 2'b11);

    // Reset asserted mid-update clears state without waiting for an edge
    @(negedge clk);
    applyStimulus(1'b1, 32'h0040_0110, 32'h0040_0500, 1'b1, 2'b11, 1'b1, 1'b1, 32'h0040_0110);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midrst.count", 32'(mispredict_count), 32'h0);
    checkLookup("midrst.lookup", 1'b0, 32'h0, 2'b01);
    @(posedge clk);
    #1;
    checkOutput("midrst.hold.count", 32'(mispredict_count), 32'h0);
    checkLookup("midrst.hold", 1'b0, 32'h0, 2'b01);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0040_0110);
    reset = 1'b1;
    @(negedge clk);
    #1;
    checkLookup("midrst.after", 1'b0, 32'h0, 2'b01);

    // Drive the mispredict counter up to its saturation limit
    @(negedge clk);
    applyStimulus(1'b1, 32'h0040_0800, 32'h0, 1'b0, 2'b01, 1'b1, 1'b0, 32'h0);
    repeat (65534) @(posedge clk);
    #1;
    checkOutput("sat.fffe", 32'(mispredict_count), 32'h0000_FFFE);
    @(posedge clk);
    #1;
    checkOutput("sat.ffff", 32'(mispredict_count), 32'h0000_FFFF);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("sat.hold", 32'(mispredict_count), 32'h0000_FFFF);

    // Randomized traffic against the reference model
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    modelClear();
    for (int n = 0; n < 800; n++) begin
      logic [31:0] lpc;
      logic [31:0] upc;
      logic [31:0] utgt;
      logic        le;
      logic        uv;
      logic        ut;
      logic        um;
      logic [1:0]  uh;
      int          li;
      int          ui;
      bit          lhit;
      bit          uhit;
      int          h;
      lpc  = 32'h0040_0000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 2) * ENTRIES * 4);
      upc  = 32'h0040_0000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 2) * ENTRIES * 4);
      utgt = $urandom & 32'hFFFF_FFFC;
      le   = 1'($urandom_range(0, 3) != 0);
      uv   = 1'($urandom_range(0, 1));
      ut   = 1'($urandom_range(0, 1));
      um   = 1'($urandom_range(0, 1));
      uh   = 2'($urandom_range(0, 3));
      @(negedge clk);
      applyStimulus(uv, upc, utgt, ut, uh, um, le, lpc);
      #1;
      li   = idxOf(lpc);
      lhit = le && (mValid[li] != 0) && (mTag[li] == tagOf(lpc));
      checkLookup($sformatf("rand%0d", n), lhit && (mCtr[li] >= 2), lhit ? mTgt[li] : 32'h0,
                  lhit ? 2'(mCtr[li]) : 2'b01);
      checkOutput($sformatf("rand%0d.count", n), 32'(mispredict_count), 32'(mCnt));
      checkOutput($sformatf("rand%0d.ghr", n), 32'(ghr_f), 32'h0);
      if (uv) begin
        ui   = idxOf(upc);
        uhit = (mValid[ui] != 0) && (mTag[ui] == tagOf(upc));
        h    = int'(uh);
        if (uhit) begin
          mCtr[ui] = ut ? ((h + 1 > 3) ? 3 : h + 1) : ((h - 1 < 0) ? 0 : h - 1);
          if (ut) mTgt[ui] = utgt;
        end else if (ut) begin
          mValid[ui] = 1;
          mTag[ui]   = tagOf(upc);
          mCtr[ui]   = 2;
          mTgt[ui]   = utgt;
        end
        if (um && mCnt < 65535) mCnt++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
